// File: rtl/alu_arbiter_pkg.sv
// Shared widths, ALU command codes and arbiter state encodings for the ALU arbiter.
package alu_arbiter_pkg;

  localparam int CD_N = 16;
  localparam int AC_N = 2;
  localparam int AA_N = 2;
  localparam int CNT_N = 4;

  localparam logic [AC_N-1:0] AC_AD = 2'd0;
  localparam logic [AC_N-1:0] AC_SB = 2'd1;
  localparam logic [AC_N-1:0] AC_MU = 2'd2;
  localparam logic [AC_N-1:0] AC_DI = 2'd3;

  typedef enum logic [AA_N-1:0] {
    AA_IDLE = 2'd0,
    AA_HOLD = 2'd1,
    AA_DONE = 2'd2
  } aa_state_t;

  // HOLD runs from LAT-1 down to 0, so capture lands LAT edges after the grant.
  function automatic logic [CNT_N-1:0] settle_load(input int lat);
    return CNT_N'(lat - 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the port that did not win last time goes.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the calculator ALU between the controller (port 0) and the display unit (port 1).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            r0_req,
  input  logic [CD_N-1:0] r0_A,
  input  logic [CD_N-1:0] r0_B,
  input  logic [AC_N-1:0] r0_cmd,
  output logic            r0_ack,
  input  logic            r1_req,
  input  logic [CD_N-1:0] r1_A,
  input  logic [CD_N-1:0] r1_B,
  input  logic [AC_N-1:0] r1_cmd,
  output logic            r1_ack,
  output logic [CD_N-1:0] res,
  output logic [CD_N-1:0] al_A,
  output logic [CD_N-1:0] al_B,
  output logic [AC_N-1:0] al_cmd,
  input  logic [CD_N-1:0] al_C,
  output logic            busy,
  output logic            gnt
);

  aa_state_t        state;
  logic [CNT_N-1:0] cnt;
  logic             last;
  logic             winner;
  logic             any;

  rr_pick2 u_pick (
    .req    ({r1_req, r0_req}),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  // Requests only matter in IDLE; every output is a register so no req reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= AA_IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      gnt    <= 1'b0;
      busy   <= 1'b0;
      al_A   <= '0;
      al_B   <= '0;
      al_cmd <= AC_AD;
      res    <= '0;
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      case (state)
        AA_IDLE: begin
          if (any) begin
            gnt    <= winner;
            last   <= winner;
            al_A   <= winner ? r1_A : r0_A;
            al_B   <= winner ? r1_B : r0_B;
            al_cmd <= winner ? r1_cmd : r0_cmd;
            cnt    <= settle_load(LAT);
            busy   <= 1'b1;
            state  <= AA_HOLD;
          end
        end
        AA_HOLD: begin
          if (cnt == '0) begin
            res    <= al_C;
            r0_ack <= ~gnt;
            r1_ack <= gnt;
            state  <= AA_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        AA_DONE: begin
          // Park the ALU on 0 + 0 while nobody owns it.
          busy   <= 1'b0;
          al_A   <= '0;
          al_B   <= '0;
          al_cmd <= AC_AD;
          state  <= AA_IDLE;
        end
        default: state <= AA_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single calculator ALU between two requesters: the main controller (port 0) and the display/number-formatting unit (port 1). Each requester presents operands and an ALU command with a req/ack handshake. The arbiter grants one requester at a time with round-robin fairness and drives the ALU inputs from registered operands. It holds them for a programmable settle time, captures the ALU result and returns it with a one-cycle ack. It sits between the controller-side operand muxing and the ALU instance.

## Interface
Parameters:
- LAT, 2, ALU settle cycles operands are held before result capture (legal range 1..15)

Ports (clock and reset first):
- Clock  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears all state on the rising edge where sampled high
- r0_req  input  1  port 0 (controller) request; held high until r0_ack
- r0_A  input  `CD_N  port 0 operand A
- r0_B  input  `CD_N  port 0 operand B
- r0_cmd  input  `AC_N  port 0 ALU command (`AC_AD/`AC_SB/`AC_MU/`AC_DI)
- r0_ack  output  1  one-cycle pulse; res valid this cycle for port 0
- r1_req, r1_A, r1_B, r1_cmd, r1_ack  same as port 0, for port 1 (display unit)
- res  output  `CD_N  captured ALU result, held until next capture
- al_A  output  `CD_N  ALU operand A
- al_B  output  `CD_N  ALU operand B
- al_cmd  output  `AC_N  ALU command
- al_C  input  `CD_N  ALU result
- busy  output  1  high whenever the ALU is granted (HOLD or DONE)
- gnt  output  1  index of current/last granted port

## Operation
- States: IDLE, HOLD, DONE.
- IDLE: samples r0_req/r1_req.
  - Neither high: stay in IDLE.
  - Exactly one high: grant that port.
  - Both high: grant the port not equal to last-grant pointer `last`.
  - On grant: register that port's A/B/cmd into al_A/al_B/al_cmd, set gnt and `last` to the winner, load counter with LAT-1, go to HOLD.
- HOLD: al_* stay constant and requester inputs are ignored. Counter decrements each cycle. When counter is 0, capture al_C into res and go to DONE.
- DONE: assert ack of the gnt port for exactly this cycle; busy stays high. Return to IDLE; requests are not sampled in DONE.
- Requester rule: deassert req on the edge ending its ack cycle. A req still high in the following IDLE cycle is a new request.
- In IDLE, al_A/al_B are 0 and al_cmd is `AC_AD, so the ALU computes 0.
- Operands and result pass through unmodified at width `CD_N. Arithmetic, overflow and division-by-zero are the ALU's responsibility.
- A requester changing operands while req is high but not yet granted is legal. Values are sampled on the grant edge.

## Timing
- Reset values: state IDLE, al_A 0, al_B 0, al_cmd `AC_AD, res 0, r0_ack 0, r1_ack 0, busy 0, gnt 0, `last` 1 (port 0 wins the first tie).
- Latency for a request sampled in IDLE at edge t:
  - al_* valid from t.
  - Result captured at edge t+LAT.
  - ack high in cycle t+LAT, i.e. LAT+1 cycles after req is first seen.
- Throughput: one operation per LAT+2 cycles. A back-to-back request from the other port is granted in the first IDLE cycle after DONE.
- Simultaneous requests: strict alternation while both remain asserted.
- Reset during HOLD or DONE aborts the operation: no ack is issued, res is cleared, and a pending req is re-arbitrated after Reset falls.
- busy is registered. No combinational path from any req input to any output.

## Structure
- Shared include (CONT_INTERNAL-style header): arbiter state encodings `AA_IDLE/`AA_HOLD/`AA_DONE and width `AA_N. Widths `CD_N and `AC_N and the `AC_* commands come from the existing ALU interface header.
- One sub-module is natural: `rr_pick2`, combinational 2-way round-robin selector with inputs req[1:0] and last, output winner and any.
- Everything else (counter, operand registers, result capture) stays in alu_arbiter.

## Test plan
- LAT=2, r0 requests A=7, B=5, cmd `AC_AD, r1 idle -> al_* = 7/5/AD the cycle after sampling; r0_ack pulses 3 cycles after req seen; res=12; r1_ack never asserts.
- Both ports request in the same cycle after reset (r0: 9·3 `AC_MU, r1: 20/4 `AC_DI) -> r0 acked first with res=27; r1 granted next IDLE, acked with res=5; gnt sequence 0,1.
- Both ports hold req continuously across 4 operations -> grants alternate 0,1,0,1; no port is acked twice in a row.
- Port 0 changes r0_A from 3 to 8 during HOLD -> al_A stays 3 and res reflects 3.
- Reset asserted in HOLD cycle 1 -> no ack; all outputs at reset values next cycle; a req still high after Reset falls is granted normally.
- LAT=1 build, single `AC_SB 4-6 -> ack 2 cycles after req seen; res equals the ALU's `AC_SB output for 4,6.
